// File: rtl/mem_sched_pkg.sv
// Shared types and default widths for the frame-buffer memory scheduler and arbiters.
package mem_sched_pkg;

  localparam int unsigned MEM_DATA_BITS_DEF = 32;
  localparam int unsigned ADDR_BITS_DEF     = 23;
  localparam int unsigned BURST_BITS_DEF    = 10;
  localparam int unsigned TIMEOUT_DEF       = 8000;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_RD_GRANT = 3'd1;
  localparam state_t ST_RD_BUSY  = 3'd2;
  localparam state_t ST_WR_GRANT = 3'd3;
  localparam state_t ST_WR_BUSY  = 3'd4;

  localparam logic GRANT_RD = 1'b0;
  localparam logic GRANT_WR = 1'b1;

endpackage

// File: rtl/mem_rw_sched_if.sv
// Requester-side and controller-side signals of the read/write scheduler.
interface mem_rw_sched_if
  import mem_sched_pkg::*;
#(
  parameter int unsigned MEM_DATA_BITS = MEM_DATA_BITS_DEF,
  parameter int unsigned ADDR_BITS     = ADDR_BITS_DEF,
  parameter int unsigned BURST_BITS    = BURST_BITS_DEF
) ();

  logic                     rd_req;
  logic [BURST_BITS-1:0]    rd_len;
  logic [ADDR_BITS-1:0]     rd_addr;
  logic                     rd_data_valid;
  logic [MEM_DATA_BITS-1:0] rd_data;
  logic                     rd_finish;

  logic                     wr_req;
  logic [BURST_BITS-1:0]    wr_len;
  logic [ADDR_BITS-1:0]     wr_addr;
  logic                     wr_data_req;
  logic [MEM_DATA_BITS-1:0] wr_data;
  logic                     wr_finish;

  logic                     mem_rd_req;
  logic [BURST_BITS-1:0]    mem_rd_len;
  logic [ADDR_BITS-1:0]     mem_rd_addr;
  logic                     mem_rd_data_valid;
  logic [MEM_DATA_BITS-1:0] mem_rd_data;
  logic                     mem_rd_finish;

  logic                     mem_wr_req;
  logic [BURST_BITS-1:0]    mem_wr_len;
  logic [ADDR_BITS-1:0]     mem_wr_addr;
  logic                     mem_wr_data_req;
  logic [MEM_DATA_BITS-1:0] mem_wr_data;
  logic                     mem_wr_finish;

  // Scheduler view.
  modport slave (
    input  rd_req, rd_len, rd_addr, wr_req, wr_len, wr_addr, wr_data,
           mem_rd_data_valid, mem_rd_data, mem_rd_finish,
           mem_wr_data_req, mem_wr_finish,
    output rd_data_valid, rd_data, rd_finish, wr_data_req, wr_finish,
           mem_rd_req, mem_rd_len, mem_rd_addr,
           mem_wr_req, mem_wr_len, mem_wr_addr, mem_wr_data
  );

  // Arbiters plus controller view.
  modport master (
    output rd_req, rd_len, rd_addr, wr_req, wr_len, wr_addr, wr_data,
           mem_rd_data_valid, mem_rd_data, mem_rd_finish,
           mem_wr_data_req, mem_wr_finish,
    input  rd_data_valid, rd_data, rd_finish, wr_data_req, wr_finish,
           mem_rd_req, mem_rd_len, mem_rd_addr,
           mem_wr_req, mem_wr_len, mem_wr_addr, mem_wr_data
  );

endinterface

// File: rtl/mem_sched_wdt.sv
// Burst watchdog: counts BUSY cycles since the last grant and flags expiry past TIMEOUT.
module mem_sched_wdt
  import mem_sched_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic mem_clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic inc_i,
  output logic expired_c
);

  localparam int unsigned CNT_BITS = $clog2(TIMEOUT + 2);

  logic [CNT_BITS-1:0] cnt_q, cnt_d;

  assign expired_c = inc_i && (cnt_q > CNT_BITS'(TIMEOUT));

  // Holding at expiry keeps the counter from wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !expired_c) begin
      cnt_d = cnt_q + CNT_BITS'(1);
    end
  end

  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mem_rw_sched.sv
// Read/write burst scheduler in front of the DDR3 controller user port.
// Optional watchdog compiled in with `define MEM_RW_SCHED_WDT_EN.
module mem_rw_sched
  import mem_sched_pkg::*;
#(
  parameter int unsigned ADDR_BITS  = ADDR_BITS_DEF,
  parameter int unsigned BURST_BITS = BURST_BITS_DEF,
  parameter int unsigned TIMEOUT    = TIMEOUT_DEF
) (
  input  logic           mem_clk,
  input  logic           rst_n,
  mem_rw_sched_if.slave  bus,
  output logic           busy,
  output logic           timeout_err
);

  state_t                state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic                  mem_rd_req_q, mem_rd_req_d;
  logic [BURST_BITS-1:0] mem_rd_len_q, mem_rd_len_d;
  logic [ADDR_BITS-1:0]  mem_rd_addr_q, mem_rd_addr_d;
  logic                  mem_wr_req_q, mem_wr_req_d;
  logic [BURST_BITS-1:0] mem_wr_len_q, mem_wr_len_d;
  logic [ADDR_BITS-1:0]  mem_wr_addr_q, mem_wr_addr_d;
  logic                  rd_finish_q, rd_finish_d;
  logic                  wr_finish_q, wr_finish_d;
  logic                  busy_q, busy_d;
  logic                  timeout_err_q, timeout_err_d;

  logic rd_valid, wr_valid, wdt_expired;

  assign rd_valid = bus.rd_req && (bus.rd_len != '0);
  assign wr_valid = bus.wr_req && (bus.wr_len != '0);

`ifdef MEM_RW_SCHED_WDT_EN
  logic in_grant, in_busy;
  assign in_grant = (state_q == ST_RD_GRANT) || (state_q == ST_WR_GRANT);
  assign in_busy  = (state_q == ST_RD_BUSY)  || (state_q == ST_WR_BUSY);

  mem_sched_wdt #(.TIMEOUT(TIMEOUT)) u_wdt (
    .mem_clk   (mem_clk),
    .rst_n     (rst_n),
    .clr_i     (in_grant),
    .inc_i     (in_busy),
    .expired_c (wdt_expired)
  );
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT;
  assign wdt_expired    = 1'b0;
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    mem_rd_req_d  = mem_rd_req_q;
    mem_rd_len_d  = mem_rd_len_q;
    mem_rd_addr_d = mem_rd_addr_q;
    mem_wr_req_d  = mem_wr_req_q;
    mem_wr_len_d  = mem_wr_len_q;
    mem_wr_addr_d = mem_wr_addr_q;
    rd_finish_d   = 1'b0;
    wr_finish_d   = 1'b0;
    timeout_err_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // On a tie the side not granted last time wins.
        if (rd_valid && (!wr_valid || (last_grant_q == GRANT_WR))) begin
          state_d      = ST_RD_GRANT;
          last_grant_d = GRANT_RD;
        end else if (wr_valid) begin
          state_d      = ST_WR_GRANT;
          last_grant_d = GRANT_WR;
        end
      end
      ST_RD_GRANT: begin
        mem_rd_len_d  = bus.rd_len;
        mem_rd_addr_d = bus.rd_addr;
        mem_rd_req_d  = 1'b1;
        state_d       = ST_RD_BUSY;
      end
      ST_RD_BUSY: begin
        if (bus.mem_rd_data_valid) mem_rd_req_d = 1'b0;
        if (bus.mem_rd_finish) begin
          mem_rd_req_d = 1'b0;
          rd_finish_d  = 1'b1;
          state_d      = ST_IDLE;
        end else if (wdt_expired) begin
          mem_rd_req_d  = 1'b0;
          rd_finish_d   = 1'b1;
          timeout_err_d = 1'b1;
          state_d       = ST_IDLE;
        end
      end
      ST_WR_GRANT: begin
        mem_wr_len_d  = bus.wr_len;
        mem_wr_addr_d = bus.wr_addr;
        mem_wr_req_d  = 1'b1;
        state_d       = ST_WR_BUSY;
      end
      ST_WR_BUSY: begin
        if (bus.mem_wr_data_req) mem_wr_req_d = 1'b0;
        if (bus.mem_wr_finish) begin
          mem_wr_req_d = 1'b0;
          wr_finish_d  = 1'b1;
          state_d      = ST_IDLE;
        end else if (wdt_expired) begin
          mem_wr_req_d  = 1'b0;
          wr_finish_d   = 1'b1;
          timeout_err_d = 1'b1;
          state_d       = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      last_grant_q  <= GRANT_WR;
      mem_rd_req_q  <= 1'b0;
      mem_rd_len_q  <= '0;
      mem_rd_addr_q <= '0;
      mem_wr_req_q  <= 1'b0;
      mem_wr_len_q  <= '0;
      mem_wr_addr_q <= '0;
      rd_finish_q   <= 1'b0;
      wr_finish_q   <= 1'b0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      mem_rd_req_q  <= mem_rd_req_d;
      mem_rd_len_q  <= mem_rd_len_d;
      mem_rd_addr_q <= mem_rd_addr_d;
      mem_wr_req_q  <= mem_wr_req_d;
      mem_wr_len_q  <= mem_wr_len_d;
      mem_wr_addr_q <= mem_wr_addr_d;
      rd_finish_q   <= rd_finish_d;
      wr_finish_q   <= wr_finish_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Data paths pass straight through, strobes gated by the matching BUSY state.
  assign bus.rd_data_valid = (state_q == ST_RD_BUSY) && bus.mem_rd_data_valid;
  assign bus.rd_data       = bus.mem_rd_data;
  assign bus.wr_data_req   = (state_q == ST_WR_BUSY) && bus.mem_wr_data_req;
  assign bus.mem_wr_data   = bus.wr_data;

  assign bus.mem_rd_req  = mem_rd_req_q;
  assign bus.mem_rd_len  = mem_rd_len_q;
  assign bus.mem_rd_addr = mem_rd_addr_q;
  assign bus.mem_wr_req  = mem_wr_req_q;
  assign bus.mem_wr_len  = mem_wr_len_q;
  assign bus.mem_wr_addr = mem_wr_addr_q;
  assign bus.rd_finish   = rd_finish_q;
  assign bus.wr_finish   = wr_finish_q;
  assign busy            = busy_q;
  assign timeout_err     = timeout_err_q;

endmodule

// File: doc/mem_rw_sched.md
# mem_rw_sched

Read/write scheduler sharing the single DDR3 controller user port between the read-arbiter side and the write-arbiter side of the frame-buffer memory subsystem. It accepts one burst request per side and grants one burst at a time with read/write alternation when both sides are pending. It forwards burst parameters, handshakes and data to the controller, and returns a one-cycle finish pulse to the granted side. An optional watchdog recovers from a controller burst that never finishes.

## Interface
- MEM_DATA_BITS, 32, data width of both paths
- ADDR_BITS, 23, burst address width
- BURST_BITS, 10, burst length width
- TIMEOUT, 8000, watchdog limit in mem_clk cycles (used only with watchdog compiled in)

Ports:
- mem_clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- rd_req / rd_len / rd_addr  in  1 / BURST_BITS / ADDR_BITS  read-side burst request, level
- rd_data_valid  out  1  read data strobe to the read side
- rd_data  out  MEM_DATA_BITS  read data to the read side
- rd_finish  out  1  read burst done pulse
- wr_req / wr_len / wr_addr  in  1 / BURST_BITS / ADDR_BITS  write-side burst request, level
- wr_data_req  out  1  write data request to the write side
- wr_data  in  MEM_DATA_BITS  write data from the write side
- wr_finish  out  1  write burst done pulse
- mem_rd_req, mem_rd_len, mem_rd_addr  out  1, BURST_BITS, ADDR_BITS  controller read command, registered
- mem_rd_data_valid, mem_rd_data, mem_rd_finish  in  1, MEM_DATA_BITS, 1  controller read response
- mem_wr_req, mem_wr_len, mem_wr_addr  out  1, BURST_BITS, ADDR_BITS  controller write command, registered
- mem_wr_data_req, mem_wr_finish  in  1, 1  controller write handshake
- mem_wr_data  out  MEM_DATA_BITS  write data to the controller
- busy  out  1  high whenever state != IDLE
- timeout_err  out  1  one-cycle watchdog pulse

## Operation
- States:
  - IDLE
  - RD_GRANT, RD_BUSY
  - WR_GRANT, WR_BUSY
- Request validity: a request is valid only if req=1 and len != 0. Zero-length requests are ignored and never granted.
- IDLE transitions:
  - Only read valid → RD_GRANT.
  - Only write valid → WR_GRANT.
  - Both valid → grant the side opposite last_grant.
  - Neither valid → stay in IDLE.
- last_grant: updates when a GRANT state is entered. Reset value = write, so reads win the first tie.
- x_GRANT (one cycle):
  - Latch x_len and x_addr into mem_x_len and mem_x_addr.
  - Set mem_x_req=1.
  - → x_BUSY.
- x_BUSY:
  - mem_x_req clears on the first mem_rd_data_valid (read) or mem_wr_data_req (write).
  - mem_x_finish → IDLE, and x_finish=1 for exactly one cycle.
- Requester dropping req after GRANT does not cancel the burst. len/addr are sampled only in GRANT.
- Data gating:
  - rd_data_valid = mem_rd_data_valid only in RD_BUSY, else 0.
  - rd_data = mem_rd_data.
  - wr_data_req = mem_wr_data_req only in WR_BUSY, else 0.
  - mem_wr_data = wr_data.
  - All four are combinational pass-through.
- Controller strobes outside the matching BUSY state are ignored.

## Timing
- Reset values: all outputs 0; state IDLE; last_grant=write.
- Grant latency: request valid sampled in IDLE at edge N → GRANT after N; mem_x_req=1 and state BUSY after N+1.
- Finish: mem_x_finish high in cycle M → x_finish=1 and state IDLE after edge M, for one cycle. Next grant is earliest after edge M+1.
- Minimum turnaround between bursts is 3 cycles (BUSY→IDLE→GRANT→BUSY).
- Reset mid-burst: immediate return to reset values. Any controller burst in flight is abandoned; its remaining strobes are ignored.

## Configuration
- MEM_RW_SCHED_WDT_EN defined: the watchdog is compiled in.
  - The counter clears on entering a GRANT state and increments in BUSY.
  - When count > TIMEOUT, the block clears mem_x_req, pulses x_finish and timeout_err in the same cycle, and returns to IDLE.
  - If mem_x_finish arrives in the expiry cycle, the finish takes precedence and timeout_err stays 0.
- Undefined: no counter; timeout_err tied to 0; BUSY waits indefinitely.

## Structure
- Package mem_sched_pkg holds:
  - the state enum (3-bit encoding)
  - the GRANT_RD/GRANT_WR constants for last_grant
  - default width constants shared with the read and write arbiters
- One sub-module: mem_sched_wdt, containing the counter, compare and expiry flag. It is instantiated only under MEM_RW_SCHED_WDT_EN.

## Test plan
- Read only, rd_len=16, rd_addr=0x1000 → mem_rd_req rises 2 cycles after rd_req. 16 rd_data_valid strobes are forwarded. rd_finish pulses 1 cycle after mem_rd_finish. busy=0 afterwards.
- rd_req and wr_req asserted together from reset, held for 4 bursts → grant order is R,W,R,W; no write strobes leak to the read side and vice versa.
- wr_req=1 with wr_len=0 → no grant, busy stays 0. Then wr_len=8 → write burst granted; 8 mem_wr_data_req strobes are mirrored on wr_data_req.
- Watchdog build, TIMEOUT=100, controller never finishes → timeout_err and rd_finish pulse together ~102 cycles after GRANT; state returns to IDLE. Repeat with mem_rd_finish in the expiry cycle → timeout_err=0.
- rst_n low in WR_BUSY mid-burst → all outputs 0 immediately. After release, a pending read tie is granted first.
